freelist_nw: RTL and testbench
==============================

Name: freelist_nw

Overview:
- N-wide physical-register free list for the superscalar rename stage; generalises the fixed 2-lane free list to WIDTH lanes.
- Supplies WIDTH new PRF tags per cycle to the maptable and accepts WIDTH released tags per cycle from retire.
- Adds branch checkpoints (save/restore of the allocation head) and a one-cycle full flush back to the committed state. This replaces the multi-cycle walk recovery.
- Sits between decode/rename and RS/ROB allocation.

Parameters:
- WIDTH, 2, allocate, free and commit lanes per cycle.
- PRF_NUM, 64, number of physical registers.
- ARF_NUM, 32, number of architectural registers. PRF 0..ARF_NUM-1 are the initial mappings and never start in the list.
- CKPT_NUM, 4, number of branch checkpoints.
- Derived: DEPTH=PRF_NUM-ARF_NUM; PRF_W=$clog2(PRF_NUM); PTR_W=$clog2(DEPTH)+1 (extra wrap bit); CKPT_W=$clog2(CKPT_NUM).

Ports:
- clk, in, 1, clock, rising edge.
- reset, in, 1, synchronous, active-high.
- alloc_req, in, WIDTH, per-lane request (lane valid, writes rd, rd!=0, no stall).
- alloc_prf, out, WIDTH*PRF_W, tag for each lane; lane i in bits [i*PRF_W +: PRF_W].
- can_alloc, out, 1, list can serve WIDTH tags this cycle.
- free_en, in, WIDTH, per-lane release of a T_old at retire.
- free_prf, in, WIDTH*PRF_W, released tags.
- commit_en, in, WIDTH, per-lane retire of an instruction that allocated a tag.
- ckpt_save, in, 1, snapshot the allocation head.
- ckpt_save_id, in, CKPT_W, snapshot slot.
- ckpt_restore, in, 1, mispredict recovery.
- ckpt_restore_id, in, CKPT_W, slot to restore.
- flush, in, 1, exception or full recovery to the committed state.
- free_count, out, PTR_W, tags currently available (tail-head).

Behaviour:
- Storage: circular buffer of DEPTH×PRF_W entries.
- Pointers: head (spec alloc), rhead (committed alloc) and tail (free insert), each PTR_W bits. Wrap is modulo 2·DEPTH; the index is the low bits.
- Reset state:
  - entry[i]=ARF_NUM+i; head=rhead=0; tail=DEPTH.
  - All checkpoints = 0; free_count=DEPTH.
  - can_alloc=0 while reset is high, and 1 on the first cycle after.
- can_alloc = (free_count >= WIDTH) & ~ckpt_restore & ~flush & ~reset. It is combinational from registered state plus the recovery inputs.
- Allocation is all-or-nothing:
  - When can_alloc=1, the requesting lanes are compacted in lane order. Lane i gets entry[head + popcount(alloc_req[i-1:0])].
  - alloc_prf is combinational, valid in the same cycle.
  - At the next edge, head += popcount(alloc_req).
  - Non-requesting lanes show the would-be tag (don't care).
  - When can_alloc=0, head does not move and alloc_prf is don't care.
- Free: enabled lanes are compacted in lane order and written at tail + popcount(free_en[i-1:0]). Then tail += popcount(free_en). Freed tags become allocatable the next cycle (no bypass).
- Commit: rhead += popcount(commit_en). rhead never passes head; this is an assertion.
- Checkpoint save: ckpt[ckpt_save_id] <= head after this cycle's allocation (head_next).
- Checkpoint restore: head <= ckpt[ckpt_restore_id]. The allocation and save inputs in the same cycle are ignored.
- Flush: head <= rhead_next, which includes same-cycle commits. Flush overrides restore. Allocation and save are ignored.
- Frees and commits are always processed, including in restore and flush cycles.
- Priority at the head pointer: reset > flush > restore > alloc.
- Boundaries:
  - free_count==WIDTH still allows a full-width allocation, after which the list is empty.
  - free_count<WIDTH gives can_alloc=0 even if fewer lanes request.
  - Pointer wrap-around is seamless.
  - free_count > DEPTH after a free is illegal (assertion).
  - Restoring a slot that was never saved gives undefined behaviour; ROB/branch logic guarantees this does not happen.
  - A same-cycle alloc and free with 0 < free_count < WIDTH is still blocked; the freed tags are usable next cycle.
  - Reset asserted mid-operation returns all state to reset values at that edge.
- free_count is registered: tail - head as PTR_W-bit modular arithmetic.

Test Plan:
- Reset, then alloc_req=2'b11 for 16 cycles (WIDTH=2) -> tags 32,33,34,…,63 in order. free_count 32→0. can_alloc=0 from cycle 17.
- Empty list; free_en=2'b11 with free_prf={40,41} -> next cycle can_alloc=1 and alloc_req=2'b11 returns lane0=41 (free lane0), lane1=40.
- alloc_req=2'b10 after reset -> lane1 gets 32. The next alloc_req=2'b11 gets 33,34. free_count goes 32→31→29.
- Allocate 4 tags, ckpt_save id 1 in the same cycle as allocating 2 more (head_next=6), allocate 4 more, then ckpt_restore id 1 with alloc_req=11 -> head=6, no allocation that cycle, and the next alloc returns 38,39.
- Allocate 10 tags, commit_en 3 lanes over 2 cycles, then flush with commit_en=2'b01 -> head=rhead=4, free_count=32-4+frees.
- Wrap: cycle 40 alloc/free pairs at full width -> the tags re-circulate in free order with no loss or duplication. Check with a scoreboard of free_count and the set of tags.

Source files
------------

// File: rtl/freelist_nw.sv
// N-wide physical-register free list for rename: WIDTH allocations and WIDTH
// releases per cycle, branch checkpoints of the allocation head, and one-cycle flush.
module freelist_nw #(
    parameter int WIDTH    = 2,
    parameter int PRF_NUM  = 64,
    parameter int ARF_NUM  = 32,
    parameter int CKPT_NUM = 4,
    localparam int DEPTH   = PRF_NUM - ARF_NUM,
    localparam int PRF_W   = $clog2(PRF_NUM),
    localparam int PTR_W   = $clog2(DEPTH) + 1,
    localparam int CKPT_W  = $clog2(CKPT_NUM)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [WIDTH-1:0]       alloc_req_i,
    output logic [WIDTH*PRF_W-1:0] alloc_prf_o,
    output logic                   can_alloc_o,
    input  logic [WIDTH-1:0]       free_en_i,
    input  logic [WIDTH*PRF_W-1:0] free_prf_i,
    input  logic [WIDTH-1:0]       commit_en_i,
    input  logic                   ckpt_save_i,
    input  logic [CKPT_W-1:0]      ckpt_save_id_i,
    input  logic                   ckpt_restore_i,
    input  logic [CKPT_W-1:0]      ckpt_restore_id_i,
    input  logic                   flush_i,
    output logic [PTR_W-1:0]       free_count_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [PRF_W-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0] ckpt_q  [CKPT_NUM];
    logic [PTR_W-1:0] head_q, head_d, rhead_q, rhead_d, tail_q, tail_d;
    logic [PTR_W-1:0] fcnt_q, fcnt_d, alloc_head;
    logic [PTR_W-1:0] alloc_cnt, free_cnt, commit_cnt;
    logic [PTR_W-1:0] rd_ptr [WIDTH];
    logic [PTR_W-1:0] wr_ptr [WIDTH];

    // Lanes are compacted: each lane's slot is offset by the enabled lanes below it.
    always_comb begin
        alloc_cnt  = '0;
        free_cnt   = '0;
        commit_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rd_ptr[i]  = head_q + alloc_cnt;
            wr_ptr[i]  = tail_q + free_cnt;
            alloc_cnt  = alloc_cnt  + PTR_W'(alloc_req_i[i]);
            free_cnt   = free_cnt   + PTR_W'(free_en_i[i]);
            commit_cnt = commit_cnt + PTR_W'(commit_en_i[i]);
        end
    end

    assign can_alloc_o  = (fcnt_q >= PTR_W'(WIDTH)) && !ckpt_restore_i && !flush_i && !reset_i;
    assign free_count_o = fcnt_q;

    always_comb begin
        alloc_prf_o = '0;
        for (int i = 0; i < WIDTH; i++)
            alloc_prf_o[i*PRF_W +: PRF_W] = entry_q[rd_ptr[i][IDX_W-1:0]];
    end

    always_comb begin
        alloc_head = can_alloc_o ? head_q + alloc_cnt : head_q;
        rhead_d    = rhead_q + commit_cnt;
        tail_d     = tail_q + free_cnt;
        if (flush_i)
            head_d = rhead_d;
        else if (ckpt_restore_i)
            head_d = ckpt_q[ckpt_restore_id_i];
        else
            head_d = alloc_head;
        fcnt_d = tail_d - head_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++)
                entry_q[i] <= PRF_W'(ARF_NUM + i);
            for (int c = 0; c < CKPT_NUM; c++)
                ckpt_q[c] <= '0;
            head_q  <= '0;
            rhead_q <= '0;
            tail_q  <= PTR_W'(DEPTH);
            fcnt_q  <= PTR_W'(DEPTH);
        end else begin
            head_q  <= head_d;
            rhead_q <= rhead_d;
            tail_q  <= tail_d;
            fcnt_q  <= fcnt_d;
            if (ckpt_save_i && !ckpt_restore_i && !flush_i)
                ckpt_q[ckpt_save_id_i] <= alloc_head;
            for (int i = 0; i < WIDTH; i++)
                if (free_en_i[i])
                    entry_q[wr_ptr[i][IDX_W-1:0]] <= free_prf_i[i*PRF_W +: PRF_W];
        end
    end

    // Retire can only commit tags that were handed out, and never overfill the list.
    a_rhead_behind: assert property (@(posedge clk_i) disable iff (reset_i)
        (PTR_W'(head_q - rhead_q) <= PTR_W'(DEPTH)));
    a_no_overfill: assert property (@(posedge clk_i) disable iff (reset_i)
        (fcnt_q <= PTR_W'(DEPTH)));

endmodule

// File: tb/tb_freelist_nw.sv
// Directed bench for freelist_nw: fill/drain, compaction, checkpoint restore,
// flush, and a queue-model wrap-around run.
module tb_freelist_nw;

    localparam int WIDTH  = 2;
    localparam int PRF_W  = 6;
    localparam int PTR_W  = 6;
    localparam int CKPT_W = 2;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic [WIDTH-1:0]       alloc_req_i;
    logic [WIDTH*PRF_W-1:0] alloc_prf_o;
    logic                   can_alloc_o;
    logic [WIDTH-1:0]       free_en_i;
    logic [WIDTH*PRF_W-1:0] free_prf_i;
    logic [WIDTH-1:0]       commit_en_i;
    logic                   ckpt_save_i;
    logic [CKPT_W-1:0]      ckpt_save_id_i;
    logic                   ckpt_restore_i;
    logic [CKPT_W-1:0]      ckpt_restore_id_i;
    logic                   flush_i;
    logic [PTR_W-1:0]       free_count_o;

    int n_checks = 0;
    int n_errors = 0;
    int fl[$];
    int infl[$];

    freelist_nw dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .alloc_req_i(alloc_req_i), .alloc_prf_o(alloc_prf_o), .can_alloc_o(can_alloc_o),
        .free_en_i(free_en_i), .free_prf_i(free_prf_i), .commit_en_i(commit_en_i),
        .ckpt_save_i(ckpt_save_i), .ckpt_save_id_i(ckpt_save_id_i),
        .ckpt_restore_i(ckpt_restore_i), .ckpt_restore_id_i(ckpt_restore_id_i),
        .flush_i(flush_i), .free_count_o(free_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lane_tag(input int i);
        return int'(alloc_prf_o[i*PRF_W +: PRF_W]);
    endfunction

    task automatic set_free(input int t1, input int t0);
        free_prf_i = {PRF_W'(t1), PRF_W'(t0)};
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        alloc_req_i       = '0;
        free_en_i         = '0;
        free_prf_i        = '0;
        commit_en_i       = '0;
        ckpt_save_i       = 1'b0;
        ckpt_save_id_i    = '0;
        ckpt_restore_i    = 1'b0;
        ckpt_restore_id_i = '0;
        flush_i           = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_i     = 1'b1;
        alloc_req_i = 2'b11;
        #1;
        check("rst_can_alloc_hi", int'(can_alloc_o), 0);
        tick();
        idle();
        reset_i = 1'b0;
        #1;
        check("rst_free_count", int'(free_count_o), 32);
        check("rst_can_alloc_lo", int'(can_alloc_o), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset_i = 1'b1;
        tick();
        do_reset();

        // fill: 16 full-width allocations drain the list in order
        for (int c = 0; c < 16; c++) begin
            alloc_req_i = 2'b11;
            #1;
            check("fill_can", int'(can_alloc_o), 1);
            check("fill_lane0", lane_tag(0), 32 + 2*c);
            check("fill_lane1", lane_tag(1), 33 + 2*c);
            check("fill_count", int'(free_count_o), 32 - 2*c);
            tick();
        end
        #1;
        check("empty_can", int'(can_alloc_o), 0);
        check("empty_count", int'(free_count_o), 0);

        // free into empty list, then reallocate in free-lane order
        idle();
        free_en_i = 2'b11; commit_en_i = 2'b11; set_free(40, 41);
        #1;
        check("free_cycle_can", int'(can_alloc_o), 0);
        tick();
        idle();
        alloc_req_i = 2'b11;
        #1;
        check("refill_can", int'(can_alloc_o), 1);
        check("refill_count", int'(free_count_o), 2);
        check("refill_lane0", lane_tag(0), 41);
        check("refill_lane1", lane_tag(1), 40);
        tick();
        idle();
        #1;
        check("redrain_count", int'(free_count_o), 0);

        // count below WIDTH blocks even a single-lane request, same-cycle free included
        free_en_i = 2'b01; commit_en_i = 2'b01; set_free(0, 50);
        tick();
        idle();
        alloc_req_i = 2'b01; free_en_i = 2'b01; commit_en_i = 2'b01; set_free(0, 51);
        #1;
        check("one_count", int'(free_count_o), 1);
        check("one_blocked", int'(can_alloc_o), 0);
        tick();
        idle();
        alloc_req_i = 2'b11;
        #1;
        check("two_count", int'(free_count_o), 2);
        check("two_can", int'(can_alloc_o), 1);
        check("two_lane0", lane_tag(0), 50);
        check("two_lane1", lane_tag(1), 51);
        tick();

        // mid-operation reset, then lane compaction
        do_reset();
        alloc_req_i = 2'b10;
        #1;
        check("cmp_lane1", lane_tag(1), 32);
        tick();
        alloc_req_i = 2'b11;
        #1;
        check("cmp_count1", int'(free_count_o), 31);
        check("cmp_b_lane0", lane_tag(0), 33);
        check("cmp_b_lane1", lane_tag(1), 34);
        tick();
        idle();
        #1;
        check("cmp_count2", int'(free_count_o), 29);

        // checkpoint save / restore
        do_reset();
        alloc_req_i = 2'b11;
        tick(); tick();
        ckpt_save_i = 1'b1; ckpt_save_id_i = 2'd1;
        tick();
        ckpt_save_i = 1'b0;
        tick(); tick();
        ckpt_restore_i = 1'b1; ckpt_restore_id_i = 2'd1;
        #1;
        check("rst_cycle_can", int'(can_alloc_o), 0);
        check("pre_restore_count", int'(free_count_o), 22);
        tick();
        ckpt_restore_i = 1'b0;
        #1;
        check("post_restore_count", int'(free_count_o), 26);
        check("post_restore_lane0", lane_tag(0), 38);
        check("post_restore_lane1", lane_tag(1), 39);
        tick();

        // flush to committed head, overriding a same-cycle restore
        do_reset();
        alloc_req_i = 2'b11; ckpt_save_i = 1'b1; ckpt_save_id_i = 2'd1;
        tick();
        ckpt_save_i = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        idle();
        commit_en_i = 2'b11;
        tick();
        commit_en_i = 2'b01;
        tick();
        flush_i = 1'b1; commit_en_i = 2'b01; alloc_req_i = 2'b11;
        ckpt_restore_i = 1'b1; ckpt_restore_id_i = 2'd1;
        free_en_i = 2'b01; set_free(0, 10);
        #1;
        check("flush_cycle_can", int'(can_alloc_o), 0);
        check("pre_flush_count", int'(free_count_o), 22);
        tick();
        idle();
        alloc_req_i = 2'b11;
        #1;
        check("post_flush_count", int'(free_count_o), 29);
        check("post_flush_lane0", lane_tag(0), 36);
        check("post_flush_lane1", lane_tag(1), 37);
        tick();

        // wrap-around: tags recirculate in free order
        do_reset();
        fl.delete();
        infl.delete();
        for (int t = 32; t < 64; t++) fl.push_back(t);
        for (int c = 0; c < 44; c++) begin
            int f0, f1;
            idle();
            alloc_req_i = 2'b11;
            if (c >= 4) begin
                f0 = infl.pop_front();
                f1 = infl.pop_front();
                free_en_i = 2'b11; commit_en_i = 2'b11; set_free(f1, f0);
            end
            #1;
            check("wrap_count", int'(free_count_o), fl.size());
            check("wrap_lane0", lane_tag(0), fl[0]);
            check("wrap_lane1", lane_tag(1), fl[1]);
            infl.push_back(fl.pop_front());
            infl.push_back(fl.pop_front());
            if (c >= 4) begin
                fl.push_back(f0);
                fl.push_back(f1);
            end
            tick();
        end
        idle();
        #1;
        check("wrap_final_count", int'(free_count_o), 24);
        check("wrap_final_can", int'(can_alloc_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
